// File: rtl/uart_tx_stream.sv
// Stream-fed UART transmitter: accepts one word per handshake in IDLE and
// serialises it as start, LSB-first data, optional parity and stop bits.
module uart_tx_stream #(
    parameter int    DATA_BITS = 8,
    parameter int    CLK_DIV   = 868,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 txd,
    output logic                 busy
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [CW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   ready_q, ready_d;
    logic                   bit_done;

    assign bit_done = (baud_q == BAUD_LAST);
    assign s_ready  = ready_q;
    assign txd      = txd_q;
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
        end
    end

    // txd_d is the level for the bit the machine enters, so the line is registered
    // and the start bit appears in the cycle right after the handshake.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ready_d = ready_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                txd_d   = 1'b1;
                if (s_valid && ready_q) begin
                    state_d = ST_START;
                    shift_d = s_data;
                    par_d   = (^s_data) ^ PAR_ODD;
                    baud_d  = '0;
                    bit_d   = '0;
                    ready_d = 1'b0;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PAR_EN) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                ready_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Randomised self-checking bench for uart_tx_stream: four instances cover
// no parity, even parity, odd parity and two stop bits at CLK_DIV=4.
module tb_uart_tx_stream;

    localparam int CLK_DIV = 4;
    localparam int DB      = 8;
    localparam int N       = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid [N];
    logic [7:0] s_data  [N];
    logic       s_ready [N];
    logic       txd     [N];
    logic       busy    [N];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    uart_tx_stream #(.DATA_BITS(DB), .CLK_DIV(CLK_DIV), .PARITY("NONE"), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .txd(txd[0]), .busy(busy[0]));
    uart_tx_stream #(.DATA_BITS(DB), .CLK_DIV(CLK_DIV), .PARITY("EVEN"), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .txd(txd[1]), .busy(busy[1]));
    uart_tx_stream #(.DATA_BITS(DB), .CLK_DIV(CLK_DIV), .PARITY("ODD"), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_data(s_data[2]), .txd(txd[2]), .busy(busy[2]));
    uart_tx_stream #(.DATA_BITS(DB), .CLK_DIV(CLK_DIV), .PARITY("NONE"), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
        .s_data(s_data[3]), .txd(txd[3]), .busy(busy[3]));

    function automatic int par_mode(input int idx);
        return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
    endfunction

    function automatic int stop_bits(input int idx);
        return (idx == 3) ? 2 : 1;
    endfunction

    // Per-cycle line waveform of one frame, built from the list of frame bits.
    function automatic int model_frame(input int idx, input logic [7:0] d, output logic [255:0] w);
        logic bits[$];
        int   n = 0;
        w = '1;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (par_mode(idx) == 1) bits.push_back(^d);
        else if (par_mode(idx) == 2) bits.push_back(~^d);
        for (int i = 0; i < stop_bits(idx); i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < CLK_DIV; k++) begin
                w[n] = bits[i];
                n++;
            end
        end
        return n;
    endfunction

    task automatic wait_ready(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_ready[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout dut%0d: s_ready=%b, required 1", idx, s_ready[idx]);
        end
    endtask

    task automatic send_frame(input int idx, input logic [7:0] d, input bit scramble, input string name);
        logic [255:0] exp_w, obs_w, exp_b, obs_b, exp_r, obs_r;
        int len;
        bit ok;
        len = model_frame(idx, d, exp_w);
        wait_ready(idx, ok);
        if (!ok) return;
        s_valid[idx] = 1'b1;
        s_data[idx]  = d;
        obs_w = '1; obs_b = '0; obs_r = '0; exp_b = '0; exp_r = '0;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            s_valid[idx] = 1'b0;
            if (scramble) s_data[idx] = 8'($urandom);
            obs_w[c] = txd[idx];
            obs_b[c] = busy[idx];
            obs_r[c] = s_ready[idx];
            if (c < len) exp_b[c] = 1'b1;
            else exp_r[c] = 1'b1;
        end
        tests++;
        if (obs_w !== exp_w) begin
            fails++;
            $display("[TB] FAIL %s_txd dut%0d data=%h: got %h, required %h", name, idx, d, obs_w[63:0], exp_w[63:0]);
        end
        tests++;
        if (obs_b !== exp_b) begin
            fails++;
            $display("[TB] FAIL %s_busy dut%0d: got %h, required %h", name, idx, obs_b[63:0], exp_b[63:0]);
        end
        tests++;
        if (obs_r !== exp_r) begin
            fails++;
            $display("[TB] FAIL %s_ready dut%0d: got %h, required %h", name, idx, obs_r[63:0], exp_r[63:0]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = 8'h00;
        end
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < N; i++) begin
            tests++;
            if ({txd[i], busy[i], s_ready[i]} !== 3'b100) begin
                fails++;
                $display("[TB] FAIL reset_outputs dut%0d: txd/busy/ready=%b, required 100", i, {txd[i], busy[i], s_ready[i]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (s_ready[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ready_before_edge: got %b, required 0", s_ready[0]);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            tests++;
            if (s_ready[i] !== 1'b1) begin
                fails++;
                $display("[TB] FAIL ready_after_edge dut%0d: got %b, required 1", i, s_ready[i]);
            end
        end
    endtask

    task automatic test_single();
        send_frame(0, 8'hA5, 1'b0, "single");
    endtask

    task automatic test_parity();
        send_frame(1, 8'h07, 1'b0, "even07");
        send_frame(2, 8'h07, 1'b0, "odd07");
        send_frame(1, 8'($urandom), 1'b0, "even_rand");
        send_frame(2, 8'($urandom), 1'b0, "odd_rand");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) send_frame(i, 8'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_data_stability();
        send_frame(0, 8'h3C, 1'b1, "stable3c");
        send_frame(3, 8'($urandom), 1'b1, "stable_rand");
    endtask

    task automatic run_back_to_back(input int idx, input logic [7:0] bytes[$]);
        logic [255:0] exp_w, obs_w, w;
        int  pos, len, total, hs, ptr;
        bit  ok, pending;
        exp_w = '1;
        pos = 1;
        foreach (bytes[b]) begin
            len = model_frame(idx, bytes[b], w);
            for (int k = 0; k < len; k++) exp_w[pos + k] = w[k];
            pos += len + 1;
        end
        total = pos + 4;
        obs_w = '1;
        hs = 0; ptr = 0; pending = 1'b0;
        wait_ready(idx, ok);
        if (!ok) return;
        s_valid[idx] = 1'b1;
        s_data[idx]  = bytes[0];
        for (int c = 0; c < total; c++) begin
            if (c > 0) @(negedge clk);
            if (pending) begin
                if (ptr < bytes.size()) s_data[idx] = bytes[ptr];
                else s_valid[idx] = 1'b0;
                pending = 1'b0;
            end
            obs_w[c] = txd[idx];
            if (s_valid[idx] && s_ready[idx]) begin
                hs++;
                ptr++;
                pending = 1'b1;
            end
        end
        s_valid[idx] = 1'b0;
        tests++;
        if (obs_w !== exp_w) begin
            fails++;
            $display("[TB] FAIL b2b_txd dut%0d: got %h, required %h", idx, obs_w[191:0], exp_w[191:0]);
        end
        tests++;
        if (hs != bytes.size()) begin
            fails++;
            $display("[TB] FAIL b2b_handshakes dut%0d: got %0d, required %0d", idx, hs, bytes.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        q = '{8'h01, 8'h02, 8'h03};
        run_back_to_back(0, q);
        q = '{8'($urandom), 8'($urandom)};
        run_back_to_back(3, q);
        q = '{8'($urandom), 8'($urandom)};
        run_back_to_back(2, q);
    endtask

    task automatic test_reset_midframe();
        logic [63:0] obs_t, obs_b;
        bit ok;
        wait_ready(0, ok);
        if (!ok) return;
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h00;
        @(negedge clk);
        s_valid[0] = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({txd[0], busy[0], s_ready[0]} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL midframe_reset: txd/busy/ready=%b, required 100", {txd[0], busy[0], s_ready[0]});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (s_ready[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midframe_release_ready: got %b, required 0", s_ready[0]);
        end
        @(negedge clk);
        tests++;
        if ({txd[0], busy[0], s_ready[0]} !== 3'b101) begin
            fails++;
            $display("[TB] FAIL midframe_idle: txd/busy/ready=%b, required 101", {txd[0], busy[0], s_ready[0]});
        end
        obs_t = '0;
        obs_b = '1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            obs_t[c] = txd[0];
            obs_b[c] = busy[0];
        end
        tests++;
        if (obs_t !== '1 || obs_b !== '0) begin
            fails++;
            $display("[TB] FAIL midframe_residual: txd %h busy %h, required all-ones and zero", obs_t, obs_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_random();
        test_data_stability();
        test_back_to_back();
        test_reset_midframe();
        send_frame(0, 8'($urandom), 1'b0, "post_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter CLK_DIV, default 868, clock cycles per bit period; legal range >= 2.
REQ-003 Parameter PARITY, default "NONE", parity mode; one of "NONE", "EVEN", "ODD".
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 s_valid  input  1  upstream byte available; this port connects to an AXI-stream-style FIFO read side.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 s_data  input  DATA_BITS  byte to transmit; LSB is sent first.
REQ-010 txd  output  1  serial line; idle level is 1.
REQ-011 busy  output  1  frame in progress.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 s_ready SHALL be 1 only in IDLE; a handshake occurs on a rising edge with s_valid & s_ready.
REQ-014 On a handshake, the block SHALL latch s_data into a shift register, load the bit counter, and enter START on the same edge.
REQ-015 s_data SHALL be sampled only at the handshake edge; later changes on s_data SHALL NOT affect the frame.
REQ-016 txd SHALL be a registered output: 0 in START, the current data LSB in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-017 Latency: txd SHALL fall in the first cycle after the handshake edge.
REQ-018 Each bit SHALL be held for exactly CLK_DIV cycles.
REQ-019 The baud counter SHALL count 0..CLK_DIV-1, reload at every bit boundary, and never wrap mid-bit.
REQ-020 DATA SHALL shift out DATA_BITS bits, LSB first, and then go to PARITY if PARITY != "NONE", otherwise to STOP.
REQ-021 The parity bit SHALL be the XOR of the latched data for "EVEN", and its inverse for "ODD".
REQ-022 STOP SHALL last STOP_BITS*CLK_DIV cycles and then return to IDLE.
REQ-023 Total frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles, where P = 1 if parity is enabled, else 0.
REQ-024 Back-to-back frames: in IDLE with s_valid already high, the handshake SHALL occur on the first IDLE cycle.
REQ-025 The inter-frame gap SHALL be exactly 1 clock of txd=1 beyond the stop bits.
REQ-026 s_valid SHALL be ignored outside IDLE; a deasserted s_valid in IDLE leaves the block in IDLE indefinitely.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 The baud counter and bit counter SHALL be sized by $clog2 of CLK_DIV and DATA_BITS, with no overflow at the maximum parameter values.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=IDLE, txd=1, busy=0, s_ready=0, and all counters and the shift register at 0.
REQ-030 Reset assertion SHALL take effect asynchronously, including mid-frame.
REQ-031 A reset mid-frame SHALL abort the frame with txd=1 immediately, and the aborted byte SHALL NOT be retransmitted.
REQ-032 s_ready SHALL first rise on the first rising clk edge after rst_n deasserts.

Verification (CLK_DIV=4, DATA_BITS=8)
REQ-033 s_data=0xA5, PARITY="NONE", STOP_BITS=1, single handshake -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for 40 cycles; s_ready low throughout.
REQ-034 PARITY="EVEN" with 0x07 -> parity bit 1; PARITY="ODD" with 0x07 -> parity bit 0; frame length 44 cycles.
REQ-035 s_valid held high with 3 queued bytes 0x01,0x02,0x03 -> three frames, each separated by exactly 1 idle cycle; exactly 3 handshakes.
REQ-036 s_data toggled every cycle after the handshake of 0x3C -> the transmitted data bits still equal 0x3C.
REQ-037 rst_n pulsed low in cycle 13 of a frame -> txd=1 and busy=0 asynchronously; after release, IDLE with s_ready=1 on the next edge; no residual bits.
REQ-038 STOP_BITS=2 -> txd stays high for 8 cycles plus a 1-cycle gap before the next start bit.
